// File: rtl/grp_counter_bank.sv
// grp_counter_bank: multi-channel gated rising-edge counter with atomic window-end snapshot on the addr/data register bus.
// Build option GRP_CNT_SATURATE_EN: live counters saturate at all-ones and set a sticky per-channel OVF bit.
module grp_counter_bank #(
   parameter int unsigned CHANNELS  = 4,
   parameter int unsigned CNT_W     = 32,
   parameter logic [7:0]  BASE_ADDR = 8'h40
) (
   input  logic                clock50Mhz,
   input  logic                key_restart,
   input  logic [7:0]          addr,
   input  logic [7:0]          data,
   input  logic                write,
   output logic [7:0]          data_out,
   input  logic [CHANNELS-1:0] count_in,
   output logic                snap_valid,
   input  logic                snap_ack,
   output logic [31:0]         window_count
);

   typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

   state_t              state, state_next;
   logic [7:0]          off;
   logic                in_win;
   logic [3:0]          reg_sel;
   logic                bus_wr;
   logic                clr;
   logic                run, oneshot;
   logic [7:0]          chsel;
   logic [31:0]         window;
   logic [31:0]         timer;
   logic                start, count_en, win_end;
   logic [CHANNELS-1:0] sync1, sync2, sync3, rise;
   logic [CHANNELS-1:0] ovf;
   logic [CNT_W-1:0]    live      [CHANNELS];
   logic [CNT_W-1:0]    live_next [CHANNELS];
   logic [CNT_W-1:0]    shadow    [CHANNELS];
   logic [31:0]         sh_sel;
   logic [7:0]          rd_val;

   assign off     = addr - BASE_ADDR;
   assign in_win  = (addr >= BASE_ADDR) && (off < 8'd16);
   assign reg_sel = off[3:0];
   assign bus_wr  = write && in_win;
   assign clr     = bus_wr && (reg_sel == 4'h0) && data[2];

   // count_in path: two sync flops, a third stage for rising-edge detect
   always_ff @(posedge clock50Mhz) begin
      if (!key_restart) begin
         sync1 <= '0;
         sync2 <= '0;
         sync3 <= '0;
      end else begin
         sync1 <= count_in;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end
   assign rise = sync2 & ~sync3;

   always_ff @(posedge clock50Mhz) begin
      if (!key_restart) begin
         run     <= 1'b0;
         oneshot <= 1'b0;
         chsel   <= '0;
         window  <= 32'd50_000_000;
      end else if (bus_wr) begin
         case (reg_sel)
            4'h0: begin
               run     <= data[0];
               oneshot <= data[1];
            end
            4'h1: chsel         <= data;
            4'h2: window[7:0]   <= data;
            4'h3: window[15:8]  <= data;
            4'h4: window[23:16] <= data;
            4'h5: window[31:24] <= data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock50Mhz) begin
      if (!key_restart) state <= IDLE;
      else              state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (start) state_next = COUNT;
         COUNT: begin
            if (!run)                    state_next = IDLE;
            else if (win_end && oneshot) state_next = HOLD;
         end
         HOLD:  if (!run) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      start    = 1'b0;
      count_en = 1'b0;
      win_end  = 1'b0;
      case (state)
         IDLE:  start = run && (window != '0);
         COUNT: begin
            count_en = run;
            win_end  = run && (timer == 32'd1);
         end
         default: ;
      endcase
   end

`ifdef GRP_CNT_SATURATE_EN
   logic [CHANNELS-1:0] ovf_set;
`endif

   always_comb begin
`ifdef GRP_CNT_SATURATE_EN
      ovf_set = '0;
`endif
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         live_next[i] = live[i];
         if (count_en && rise[i]) begin
`ifdef GRP_CNT_SATURATE_EN
            if (live[i] == '1) ovf_set[i] = 1'b1;
            else               live_next[i] = live[i] + CNT_W'(1);
`else
            live_next[i] = live[i] + CNT_W'(1);
`endif
         end
      end
   end

`ifdef GRP_CNT_SATURATE_EN
   always_ff @(posedge clock50Mhz) begin
      if (!key_restart || clr) ovf <= '0;
      else                     ovf <= ovf | ovf_set;
   end
`else
   assign ovf = '0;
`endif

   // The shadow takes live_next so an edge landing on the window-end cycle is kept.
   always_ff @(posedge clock50Mhz) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (!key_restart || clr) begin
            live[i]   <= '0;
            shadow[i] <= '0;
         end else if (start) begin
            live[i] <= '0;
         end else if (win_end) begin
            shadow[i] <= live_next[i];
            live[i]   <= '0;
         end else begin
            live[i] <= live_next[i];
         end
      end
   end

   always_ff @(posedge clock50Mhz) begin
      if (!key_restart) begin
         timer        <= '0;
         snap_valid   <= 1'b0;
         window_count <= '0;
      end else begin
         if (start || win_end) timer <= window;
         else if (count_en)    timer <= timer - 32'd1;

         if (win_end)       snap_valid <= 1'b1;
         else if (snap_ack) snap_valid <= 1'b0;

         if (clr || start)  window_count <= '0;
         else if (win_end)  window_count <= window_count + 32'd1;
      end
   end

   always_comb begin
      sh_sel = '0;
      for (int unsigned i = 0; i < CHANNELS; i++)
         if (chsel == 8'(i)) sh_sel = 32'(shadow[i]);
      rd_val = '0;
      case (reg_sel)
         4'h0: rd_val = {3'b000, |ovf, snap_valid, 1'b0, oneshot, run};
         4'h1: rd_val = chsel;
         4'h2: rd_val = window[7:0];
         4'h3: rd_val = window[15:8];
         4'h4: rd_val = window[23:16];
         4'h5: rd_val = window[31:24];
         4'h6: rd_val = sh_sel[7:0];
         4'h7: rd_val = sh_sel[15:8];
         4'h8: rd_val = sh_sel[23:16];
         4'h9: rd_val = sh_sel[31:24];
         4'hA: rd_val = 8'(ovf);
         4'hF: rd_val = 8'h20;
         default: rd_val = '0;
      endcase
      if (!in_win) rd_val = '0;
   end

   always_ff @(posedge clock50Mhz) begin
      if (!key_restart) data_out <= '0;
      else              data_out <= rd_val;
   end

endmodule

// File: tb/tb_grp_counter_bank.sv
// Directed bench for grp_counter_bank: a default 32-bit instance plus an 8-bit instance for overflow behaviour.
module tb_grp_counter_bank;

   logic        clk;
   logic        key_restart;
   logic [7:0]  addr, data;
   logic        write, snap_ack;
   logic [3:0]  count_in, count_in8;
   logic [7:0]  data_out, data_out8;
   logic        snap_valid, snap_valid8;
   logic [31:0] window_count, window_count8;
   int          checks;
   int          errors;
   logic [7:0]  v;

   grp_counter_bank dut (
      .clock50Mhz(clk), .key_restart(key_restart), .addr(addr), .data(data), .write(write),
      .data_out(data_out), .count_in(count_in), .snap_valid(snap_valid), .snap_ack(snap_ack),
      .window_count(window_count)
   );

   grp_counter_bank #(.CNT_W(8)) dut8 (
      .clock50Mhz(clk), .key_restart(key_restart), .addr(addr), .data(data), .write(write),
      .data_out(data_out8), .count_in(count_in8), .snap_valid(snap_valid8), .snap_ack(snap_ack),
      .window_count(window_count8)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [3:0] r, input logic [7:0] d);
      @(negedge clk);
      addr  = {4'h4, r};
      data  = d;
      write = 1'b1;
      @(negedge clk);
      write = 1'b0;
   endtask

   task automatic rdchk(input string tag, input logic [3:0] r, input logic [7:0] exp, input bit use8);
      @(negedge clk);
      addr = {4'h4, r};
      @(negedge clk);
      chk(tag, use8 ? data_out8 : data_out, exp);
   endtask

   task automatic set_window(input logic [31:0] w);
      wr(4'h2, w[7:0]);
      wr(4'h3, w[15:8]);
      wr(4'h4, w[23:16]);
      wr(4'h5, w[31:24]);
   endtask

   task automatic pulse(input int ch, input bit use8);
      @(negedge clk);
      if (use8) count_in8[ch] = 1'b1; else count_in[ch] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      if (use8) count_in8[ch] = 1'b0; else count_in[ch] = 1'b0;
      @(negedge clk);
   endtask

   task automatic ack();
      @(negedge clk);
      snap_ack = 1'b1;
      @(negedge clk);
      snap_ack = 1'b0;
   endtask

   task automatic wait_snap(input string tag, input int budget, input bit use8);
      bit found;
      found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         found = use8 ? snap_valid8 : snap_valid;
      end
      chk(tag, 32'(found), 32'd1);
   endtask

   initial begin
      checks = 0; errors = 0;
      key_restart = 1'b0; addr = '0; data = '0; write = 1'b0; snap_ack = 1'b0;
      count_in = '0; count_in8 = '0;
      repeat (3) @(negedge clk);
      key_restart = 1'b1;

      // T1: activity, then a one-cycle reset
      set_window(32'd10);
      wr(4'h0, 8'h01);
      repeat (3) pulse(0, 1'b0);
      repeat (30) @(negedge clk);
      addr = 8'h4F;
      key_restart = 1'b0;
      @(negedge clk);
      key_restart = 1'b1;
      chk("t1_data_out", data_out, 8'h00);
      chk("t1_snap_valid", snap_valid, 1'b0);
      chk("t1_window_count", window_count, 32'd0);
      rdchk("t1_ctrl", 4'h0, 8'h00, 0);
      rdchk("t1_chsel", 4'h1, 8'h00, 0);
      rdchk("t1_win0", 4'h2, 8'h80, 0);
      rdchk("t1_win1", 4'h3, 8'hF0, 0);
      rdchk("t1_win2", 4'h4, 8'hFA, 0);
      rdchk("t1_win3", 4'h5, 8'h02, 0);
      rdchk("t1_shadow0", 4'h6, 8'h00, 0);
      rdchk("t1_ovf", 4'hA, 8'h00, 0);
      rdchk("t1_version", 4'hF, 8'h20, 0);
      rdchk("t1_reserved", 4'hE, 8'h00, 0);

      // T2: free-run, 7 edges on ch1 per 100-cycle window
      wr(4'h1, 8'h01);
      set_window(32'd100);
      wr(4'h0, 8'h01);
      repeat (7) pulse(1, 1'b0);
      wait_snap("t2_snap1", 200, 0);
      chk("t2_wc1", window_count, 32'd1);
      rdchk("t2_sh1_b0", 4'h6, 8'h07, 0);
      rdchk("t2_sh1_b1", 4'h7, 8'h00, 0);
      repeat (7) pulse(1, 1'b0);
      ack();
      chk("t2_acked", snap_valid, 1'b0);
      repeat (65) @(negedge clk);
      chk("t2_wc_before", window_count, 32'd1);
      @(negedge clk);
      chk("t2_wc_after", window_count, 32'd2);
      chk("t2_snap2", snap_valid, 1'b1);
      rdchk("t2_sh1_w2", 4'h6, 8'h07, 0);
      wr(4'h1, 8'h00);
      rdchk("t2_sh0", 4'h6, 8'h00, 0);
      wr(4'h1, 8'h03);
      rdchk("t2_sh3", 4'h6, 8'h00, 0);
      wr(4'h1, 8'h05);
      rdchk("t2_chsel_oor", 4'h1, 8'h05, 0);
      rdchk("t2_sh_oor", 4'h6, 8'h00, 0);
      wr(4'h1, 8'h01);

      // T6: stop mid-window, WINDOW=0 with run=1 stays idle, then clr
      wr(4'h0, 8'h00);
      ack();
      set_window(32'd0);
      wr(4'h0, 8'h01);
      repeat (150) @(negedge clk);
      chk("t6_snap_valid", snap_valid, 1'b0);
      chk("t6_wc_kept", window_count, 32'd2);
      rdchk("t6_sh_kept", 4'h6, 8'h07, 0);
      rdchk("t6_ctrl", 4'h0, 8'h01, 0);
      wr(4'h0, 8'h05);
      rdchk("t6_sh_clr", 4'h6, 8'h00, 0);
      chk("t6_wc_clr", window_count, 32'd0);
      rdchk("t6_ctrl_after_clr", 4'h0, 8'h01, 0);
      wr(4'h0, 8'h00);

      // T3: one-shot, 20-cycle window, 5 edges on ch2
      set_window(32'd20);
      wr(4'h1, 8'h02);
      wr(4'h0, 8'h03);
      repeat (5) pulse(2, 1'b0);
      wait_snap("t3_snap", 100, 0);
      chk("t3_wc", window_count, 32'd1);
      rdchk("t3_sh2", 4'h6, 8'h05, 0);
      ack();
      repeat (200) @(negedge clk);
      chk("t3_wc_hold", window_count, 32'd1);
      chk("t3_no_resnap", snap_valid, 1'b0);
      rdchk("t3_ctrl", 4'h0, 8'h03, 0);

      // T4: edge on the window-end cycle; ack coincident with window end
      wr(4'h0, 8'h00);
      set_window(32'd40);
      wr(4'h0, 8'h01);
      wait_snap("t4_snap1", 100, 0);
      snap_ack = 1'b1;
      @(negedge clk);
      snap_ack = 1'b0;
      repeat (36) @(negedge clk);
      count_in[2] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      count_in[2] = 1'b0;
      wait_snap("t4_snap2", 1, 0);
      snap_ack = 1'b1;
      @(negedge clk);
      snap_ack = 1'b0;
      rdchk("t4_edge_in_closing", 4'h6, 8'h01, 0);
      chk("t4_acked", snap_valid, 1'b0);
      repeat (36) @(negedge clk);
      snap_ack = 1'b1;
      @(negedge clk);
      snap_ack = 1'b0;
      chk("t4_ack_vs_end", snap_valid, 1'b1);
      chk("t4_wc", window_count, 32'd3);
      rdchk("t4_next_zero", 4'h6, 8'h00, 0);

      // T5: 300 edges into the 8-bit instance
      wr(4'h0, 8'h00);
      ack();
      wr(4'h0, 8'h04);
      set_window(32'd2000);
      wr(4'h1, 8'h00);
      wr(4'h0, 8'h03);
      repeat (300) pulse(0, 1'b1);
      wait_snap("t5_snap", 1000, 1);
      chk("t5_wc8", window_count8, 32'd1);
`ifdef GRP_CNT_SATURATE_EN
      rdchk("t5_sh_b0", 4'h6, 8'hFF, 1);
      rdchk("t5_ovf", 4'hA, 8'h01, 1);
      rdchk("t5_ctrl", 4'h0, 8'h1B, 1);
`else
      rdchk("t5_sh_b0", 4'h6, 8'h2C, 1);
      rdchk("t5_ovf", 4'hA, 8'h00, 1);
      rdchk("t5_ctrl", 4'h0, 8'h0B, 1);
`endif
      rdchk("t5_sh_b1", 4'h7, 8'h00, 1);
      rdchk("t5_wide_sh", 4'h6, 8'h00, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
